life_stepper: RTL and testbench
===============================

LIFE_STEPPER -- requirements
Module: life_stepper

Interface
REQ-001 Parameter ARENA_WIDTH, default 10, cells per row (columns), range 3..64.
REQ-002 Parameter ARENA_HEIGHT, default 10, rows in arena, range 3..256.
REQ-003 Parameter POP_WIDTH, default $clog2(ARENA_WIDTH*ARENA_HEIGHT+1), width of population count.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request a run; sampled only while ready=1.
REQ-007 wrap  in  1  sampled with start: 1=toroidal edges, 0=cells outside arena are dead.
REQ-008 generations_count  in  32  generations to compute, sampled with start.
REQ-009 ready  out  1  idle and able to accept start.
REQ-010 stable  out  1  last run ended early because a generation produced no change.
REQ-011 generations_done  out  32  generations committed in last/current run.
REQ-012 population  out  POP_WIDTH  live cells in most recently completed generation.
REQ-013 arena_row_select  out  8  arena row address.
REQ-014 arena_columns  in  ARENA_WIDTH  read data; valid in the cycle after arena_row_select is presented.
REQ-015 arena_columns_new  out  ARENA_WIDTH  write data.
REQ-016 arena_columns_write  out  1  write strobe; arena writes arena_columns_new to arena_row_select at the rising edge.

Function
REQ-017 Bit i of a row is column i; neighbours of column 0 in wrap mode include column ARENA_WIDTH-1 and vice versa; same for rows 0 and ARENA_HEIGHT-1.
REQ-018 Next state: live cell with 2 or 3 live neighbours stays live; dead cell with exactly 3 becomes live; all others dead.
REQ-019 States: IDLE, PRE_ADDR, PRE_CAP, ROW_ADDR, ROW_CAP, ROW_WRITE, GEN_END.
REQ-020 IDLE: ready=1; start=1 with generations_count=0 -> stays IDLE, clears stable and generations_done, ready stays 1; start=1 otherwise -> PRE_ADDR, ready=0 next cycle.
REQ-021 Prefetch: PRE_ADDR/PRE_CAP run twice: first row ARENA_HEIGHT-1 into prev (forced zero if wrap=0), then row 0 into cur and into first_row copy.
REQ-022 Per row r: ROW_ADDR presents r+1; ROW_CAP captures next (for r=ARENA_HEIGHT-1: first_row if wrap else zero, no arena read needed but cycle still spent); ROW_WRITE writes new row r, then prev<=cur, cur<=next.
REQ-023 One generation takes exactly 3*ARENA_HEIGHT+5 cycles from leaving IDLE/GEN_END to the next GEN_END exit.
REQ-024 arena_columns_write is high only in ROW_WRITE, exactly ARENA_HEIGHT pulses per generation.
REQ-025 Per generation the block accumulates popcount of written rows and a changed flag (new row != cur for any row).
REQ-026 GEN_END: population<=accumulated count, generations_done+=1; if changed=0 -> stable=1, IDLE; else if generations_done reaches generations_count -> IDLE; else PRE_ADDR.
REQ-027 start while ready=0 is ignored; wrap and generations_count changes mid-run have no effect.
REQ-028 generations_done wraps modulo 2^32 (no saturation); population never exceeds ARENA_WIDTH*ARENA_HEIGHT.

Reset
REQ-029 reset asserted at any time (including mid-generation) -> IDLE immediately: ready=1, stable=0, generations_done=0, population=0, arena_row_select=0, arena_columns_new=0, arena_columns_write=0; partially updated arena contents are not restored.

Structure
REQ-030 Shared package holds state encoding and the neighbour-rule constants (SURVIVE_2, SURVIVE_3, BIRTH_3).
REQ-031 One combinational sub-module life_row_next computes a new row from prev/cur/next rows and wrap, instantiated once.

Verification
REQ-032 10x10, wrap=0, horizontal blinker centred at row 4 cols 3..5, 1 gen -> vertical blinker rows 3..5 col 4, population=3, stable=0, done after 35 cycles.
REQ-033 10x10, wrap=0, 2x2 block, 10 gens -> stops after 1 gen, stable=1, generations_done=1, arena unchanged.
REQ-034 10x10, wrap=1, glider, 40 gens -> glider back at start position, population=5; same with wrap=0 -> glider dies at edge.
REQ-035 generations_count=0 with start -> ready never drops, no write strobes, generations_done=0.
REQ-036 Reset asserted in cycle 20 of a run -> all outputs at reset values next cycle; subsequent start completes normally.
REQ-037 start pulsed while ready=0 -> ignored; write strobe count equals ARENA_HEIGHT*generations_done.

Source files
------------

// File: rtl/life_stepper_pkg.sv
// Shared definitions for the Game of Life stepper: controller state encoding
// and the neighbour-count constants of the life rule.
package life_stepper_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE_ADDR,
      PRE_CAP,
      ROW_ADDR,
      ROW_CAP,
      ROW_WRITE,
      GEN_END
   } state_t;

   localparam logic [3:0] SURVIVE_2 = 4'd2;
   localparam logic [3:0] SURVIVE_3 = 4'd3;
   localparam logic [3:0] BIRTH_3   = 4'd3;

   localparam int ROW_SEL_W = 8;

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation row: applies the life rule to every column of
// cur_row using the rows above (prev_row) and below (next_row).
module life_row_next
   import life_stepper_pkg::*;
#(
   parameter int ARENA_WIDTH = 10
) (
   input  logic [ARENA_WIDTH-1:0] prev_row,
   input  logic [ARENA_WIDTH-1:0] cur_row,
   input  logic [ARENA_WIDTH-1:0] next_row,
   input  logic                   wrap,
   output logic [ARENA_WIDTH-1:0] new_row
);

   // west: bit i sees column i-1; east: bit i sees column i+1. The bit shifted
   // in at the arena edge is only live on a torus.
   function automatic logic [ARENA_WIDTH-1:0] west(input logic [ARENA_WIDTH-1:0] r,
                                                    input logic w);
      return {r[ARENA_WIDTH-2:0], w & r[ARENA_WIDTH-1]};
   endfunction

   function automatic logic [ARENA_WIDTH-1:0] east(input logic [ARENA_WIDTH-1:0] r,
                                                    input logic w);
      return {w & r[0], r[ARENA_WIDTH-1:1]};
   endfunction

   logic [ARENA_WIDTH-1:0] nbr [8];
   logic [3:0]             cnt;

   assign nbr[0] = west(prev_row, wrap);
   assign nbr[1] = prev_row;
   assign nbr[2] = east(prev_row, wrap);
   assign nbr[3] = west(cur_row, wrap);
   assign nbr[4] = east(cur_row, wrap);
   assign nbr[5] = west(next_row, wrap);
   assign nbr[6] = next_row;
   assign nbr[7] = east(next_row, wrap);

   always_comb begin
      new_row = '0;
      cnt     = '0;
      for (int i = 0; i < ARENA_WIDTH; i++) begin
         cnt = '0;
         for (int k = 0; k < 8; k++) begin
            cnt = cnt + {3'b000, nbr[k][i]};
         end
         new_row[i] = cur_row[i] ? ((cnt == SURVIVE_2) || (cnt == SURVIVE_3))
                                 : (cnt == BIRTH_3);
      end
   end

endmodule

// File: rtl/life_stepper.sv
// Game of Life stepper: streams an external row-addressed arena through a
// three-row window, rewriting it in place one generation at a time.
module life_stepper
   import life_stepper_pkg::*;
#(
   parameter int ARENA_WIDTH  = 10,
   parameter int ARENA_HEIGHT = 10,
   parameter int POP_WIDTH    = $clog2(ARENA_WIDTH*ARENA_HEIGHT+1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   wrap,
   input  logic [31:0]            generations_count,
   output logic                   ready,
   output logic                   stable,
   output logic [31:0]            generations_done,
   output logic [POP_WIDTH-1:0]   population,
   output logic [ROW_SEL_W-1:0]   arena_row_select,
   input  logic [ARENA_WIDTH-1:0] arena_columns,
   output logic [ARENA_WIDTH-1:0] arena_columns_new,
   output logic                   arena_columns_write
);

   localparam logic [ROW_SEL_W-1:0] LAST_ROW = ROW_SEL_W'(ARENA_HEIGHT-1);

   function automatic logic [POP_WIDTH-1:0] row_popcount(input logic [ARENA_WIDTH-1:0] r);
      logic [POP_WIDTH-1:0] n;
      n = '0;
      for (int i = 0; i < ARENA_WIDTH; i++) begin
         n = n + POP_WIDTH'(r[i]);
      end
      return n;
   endfunction

   state_t                 state, state_nxt;
   logic                   pre_second;
   logic [ROW_SEL_W-1:0]   row;
   logic                   wrap_q;
   logic [31:0]            gen_target;
   logic [31:0]            done_inc;
   logic                   last_row;
   logic [ROW_SEL_W-1:0]   pre_sel;
   logic [ROW_SEL_W-1:0]   fetch_sel;

   logic [ARENA_WIDTH-1:0] prev_row, cur_row, next_row, first_row, new_row;
   logic [POP_WIDTH-1:0]   pop_acc;
   logic                   changed;

   assign done_inc  = generations_done + 32'd1;
   assign last_row  = (row == LAST_ROW);
   // First prefetch pass reads the bottom row (top neighbour of row 0), second reads row 0.
   assign pre_sel   = pre_second ? '0 : LAST_ROW;
   assign fetch_sel = last_row ? '0 : row + 8'd1;

   life_row_next #(
      .ARENA_WIDTH (ARENA_WIDTH)
   ) u_row_next (
      .prev_row (prev_row),
      .cur_row  (cur_row),
      .next_row (next_row),
      .wrap     (wrap_q),
      .new_row  (new_row)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt           = state;
      ready               = 1'b0;
      arena_row_select    = '0;
      arena_columns_new   = '0;
      arena_columns_write = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start && (generations_count != 32'd0)) state_nxt = PRE_ADDR;
         end
         PRE_ADDR: begin
            arena_row_select = pre_sel;
            state_nxt        = PRE_CAP;
         end
         PRE_CAP: begin
            arena_row_select = pre_sel;
            state_nxt        = pre_second ? ROW_ADDR : PRE_ADDR;
         end
         ROW_ADDR: begin
            arena_row_select = fetch_sel;
            state_nxt        = ROW_CAP;
         end
         ROW_CAP: begin
            arena_row_select = fetch_sel;
            state_nxt        = ROW_WRITE;
         end
         ROW_WRITE: begin
            arena_row_select    = row;
            arena_columns_new   = new_row;
            arena_columns_write = 1'b1;
            state_nxt           = last_row ? GEN_END : ROW_ADDR;
         end
         GEN_END: begin
            if (!changed)                    state_nxt = IDLE;
            else if (done_inc == gen_target) state_nxt = IDLE;
            else                             state_nxt = PRE_ADDR;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_second       <= 1'b0;
         row              <= '0;
         wrap_q           <= 1'b0;
         gen_target       <= '0;
         stable           <= 1'b0;
         generations_done <= '0;
         population       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  stable           <= 1'b0;
                  generations_done <= '0;
                  wrap_q           <= wrap;
                  gen_target       <= generations_count;
               end
            end
            PRE_CAP: begin
               pre_second <= ~pre_second;
               row        <= '0;
            end
            ROW_WRITE: row <= row + 8'd1;
            GEN_END: begin
               population       <= pop_acc;
               generations_done <= done_inc;
               if (!changed) stable <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Row window and per-generation statistics; every field is initialised
   // during the prefetch before it is consumed, so no reset is needed here.
   always_ff @(posedge clk) begin
      case (state)
         PRE_ADDR: begin
            if (!pre_second) begin
               pop_acc <= '0;
               changed <= 1'b0;
            end
         end
         PRE_CAP: begin
            if (!pre_second) begin
               prev_row <= wrap_q ? arena_columns : '0;
            end else begin
               cur_row   <= arena_columns;
               first_row <= arena_columns;
            end
         end
         ROW_CAP: begin
            // Row 0 is already overwritten by now, so the bottom row wraps to the saved copy.
            next_row <= last_row ? (wrap_q ? first_row : '0) : arena_columns;
         end
         ROW_WRITE: begin
            prev_row <= cur_row;
            cur_row  <= next_row;
            pop_acc  <= pop_acc + row_popcount(new_row);
            changed  <= changed | (new_row != cur_row);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_life_stepper.sv
// Directed bench for life_stepper on a 10x10 arena backed by a
// synchronous-read row memory model.
module tb_life_stepper;

   localparam int W  = 10;
   localparam int H  = 10;
   localparam int PW = $clog2(W*H+1);

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          wrap;
   logic [31:0]   generations_count;
   logic          ready;
   logic          stable;
   logic [31:0]   generations_done;
   logic [PW-1:0] population;
   logic [7:0]    arena_row_select;
   logic [W-1:0]  arena_columns;
   logic [W-1:0]  arena_columns_new;
   logic          arena_columns_write;

   logic          load_en = 1'b0;
   logic [7:0]    load_addr = '0;
   logic [W-1:0]  load_data = '0;
   logic [W-1:0]  mem [0:255];
   int            wr_cnt = 0;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] pat_empty   [H];
   logic [W-1:0] pat_blink_h [H];
   logic [W-1:0] pat_blink_v [H];
   logic [W-1:0] pat_block   [H];
   logic [W-1:0] pat_glider  [H];
   logic [W-1:0] pat_corner  [H];

   life_stepper #(
      .ARENA_WIDTH  (W),
      .ARENA_HEIGHT (H)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .wrap                (wrap),
      .generations_count   (generations_count),
      .ready               (ready),
      .stable              (stable),
      .generations_done    (generations_done),
      .population          (population),
      .arena_row_select    (arena_row_select),
      .arena_columns       (arena_columns),
      .arena_columns_new   (arena_columns_new),
      .arena_columns_write (arena_columns_write)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
      else if (arena_columns_write) mem[arena_row_select] <= arena_columns_new;
      arena_columns <= mem[arena_row_select];
      if (arena_columns_write) wr_cnt <= wr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic load_arena(input logic [W-1:0] rows [H]);
      for (int r = 0; r < H; r++) begin
         @(negedge clk);
         load_en   = 1'b1;
         load_addr = 8'(r);
         load_data = rows[r];
      end
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic check_arena(input string tag, input logic [W-1:0] rows [H]);
      for (int r = 0; r < H; r++) begin
         check($sformatf("%s_row%0d", tag, r), 32'(mem[8'(r)]), 32'(rows[r]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(ready), 32'd1);
      check({tag, "_stable"}, 32'(stable), 32'd0);
      check({tag, "_done"}, generations_done, 32'd0);
      check({tag, "_pop"}, 32'(population), 32'd0);
      check({tag, "_sel"}, 32'(arena_row_select), 32'd0);
      check({tag, "_new"}, 32'(arena_columns_new), 32'd0);
      check({tag, "_wr"}, 32'(arena_columns_write), 32'd0);
   endtask

   // Presents start for one rising edge; returns just after that edge.
   task automatic launch(input logic w, input logic [31:0] cnt);
      @(negedge clk);
      start             = 1'b1;
      wrap              = w;
      generations_count = cnt;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_ready(input int budget, output int cyc);
      cyc = 0;
      while (!ready && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int cyc_pre;
      int wr0;

      pat_empty   = '{default: '0};
      pat_blink_h = '{4: 10'h038, default: '0};
      pat_blink_v = '{3: 10'h010, 4: 10'h010, 5: 10'h010, default: '0};
      pat_block   = '{4: 10'h030, 5: 10'h030, default: '0};
      pat_glider  = '{1: 10'h004, 2: 10'h008, 3: 10'h00E, default: '0};
      // A glider running into the dead bottom-right corner settles into a
      // 2x2 block after 27 generations; generation 28 reports no change.
      pat_corner  = '{8: 10'h300, 9: 10'h300, default: '0};

      reset             = 1'b1;
      start             = 1'b0;
      wrap              = 1'b0;
      generations_count = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      reset = 1'b0;

      // Horizontal blinker, one generation, dead edges.
      load_arena(pat_blink_h);
      wr0 = wr_cnt;
      launch(1'b0, 32'd1);
      check("blink_busy", 32'(ready), 32'd0);
      wait_ready(200, cyc);
      check("blink_cycles", 32'(cyc), 32'd35);
      check("blink_writes", 32'(wr_cnt - wr0), 32'd10);
      check("blink_pop", 32'(population), 32'd3);
      check("blink_stable", 32'(stable), 32'd0);
      check("blink_done", generations_done, 32'd1);
      check_arena("blink", pat_blink_v);

      // Still life: run stops after the first unchanged generation.
      load_arena(pat_block);
      launch(1'b0, 32'd10);
      wait_ready(500, cyc);
      check("block_cycles", 32'(cyc), 32'd35);
      check("block_stable", 32'(stable), 32'd1);
      check("block_done", generations_done, 32'd1);
      check("block_pop", 32'(population), 32'd4);
      check_arena("block", pat_block);

      // Zero-generation request clears status without leaving IDLE.
      wr0 = wr_cnt;
      launch(1'b1, 32'd0);
      check("zero_ready", 32'(ready), 32'd1);
      check("zero_done", generations_done, 32'd0);
      check("zero_stable", 32'(stable), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("zero_ready_hold", 32'(ready), 32'd1);
      check("zero_writes", 32'(wr_cnt - wr0), 32'd0);

      // Glider on a torus returns home after 40 generations.
      load_arena(pat_glider);
      wr0 = wr_cnt;
      launch(1'b1, 32'd40);
      wait_ready(2000, cyc);
      check("glw_cycles", 32'(cyc), 32'd1400);
      check("glw_done", generations_done, 32'd40);
      check("glw_pop", 32'(population), 32'd5);
      check("glw_stable", 32'(stable), 32'd0);
      check("glw_writes", 32'(wr_cnt - wr0), 32'd400);
      check_arena("glw", pat_glider);

      // Same glider with dead edges collapses into a corner block.
      load_arena(pat_glider);
      launch(1'b0, 32'd40);
      wait_ready(2000, cyc);
      check("gld_done", generations_done, 32'd28);
      check("gld_stable", 32'(stable), 32'd1);
      check("gld_pop", 32'(population), 32'd4);
      check_arena("gld", pat_corner);

      // Asynchronous reset part-way through a generation.
      load_arena(pat_blink_h);
      launch(1'b0, 32'd1);
      repeat (19) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      reset = 1'b0;
      load_arena(pat_blink_h);
      launch(1'b0, 32'd1);
      wait_ready(200, cyc);
      check("postrst_cycles", 32'(cyc), 32'd35);
      check("postrst_done", generations_done, 32'd1);
      check("postrst_pop", 32'(population), 32'd3);
      check_arena("postrst", pat_blink_v);

      // start/wrap/count changes while busy must be ignored.
      load_arena(pat_blink_h);
      wr0 = wr_cnt;
      launch(1'b0, 32'd2);
      cyc_pre = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         cyc_pre++;
      end
      @(negedge clk);
      start             = 1'b1;
      wrap              = 1'b1;
      generations_count = 32'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc_pre++;
      check("busy_ready", 32'(ready), 32'd0);
      wait_ready(300, cyc);
      check("busy_cycles", 32'(cyc_pre + cyc), 32'd70);
      check("busy_done", generations_done, 32'd2);
      check("busy_writes", 32'(wr_cnt - wr0), 32'(H) * generations_done);
      check("busy_pop", 32'(population), 32'd3);
      check_arena("busy", pat_blink_h);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
